// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program sequencer: run state and instruction opcodes.
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } pc_seq_state_t;

   localparam int unsigned OPCODE_W = 4;

   localparam logic [OPCODE_W-1:0] OP_NOP  = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_LOAD = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_STOR = 4'h2;
   localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h3;
   localparam logic [OPCODE_W-1:0] OP_SUB  = 4'h4;
   localparam logic [OPCODE_W-1:0] OP_BLQZ = 4'h5;
   localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;

   function automatic logic isHalt(input logic [OPCODE_W-1:0] opcode);
      return opcode == OP_HALT;
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the per-instruction control FSM and the program sequencer.
interface pc_sequencer_if #(
   parameter int unsigned PC_W     = 10,
   parameter int unsigned OFFSET_W = 8,
   parameter int unsigned CNT_W    = 16
);

   logic                start;
   logic                next_ins;
   logic                halt_ins;
   logic                branch_en;
   logic                branch_cond;
   logic [OFFSET_W-1:0] branch_offset;
   logic [PC_W-1:0]     pc;
   logic                running;
   logic                done;
   logic                fault;
   logic [CNT_W-1:0]    ins_count;

   modport master (
      output start, next_ins, halt_ins, branch_en, branch_cond, branch_offset,
      input  pc, running, done, fault, ins_count
   );

   modport slave (
      input  start, next_ins, halt_ins, branch_en, branch_cond, branch_offset,
      output pc, running, done, fault, ins_count
   );

endinterface

// File: rtl/pc_target_calc.sv
// Relative branch target: sign-extends the offset, adds it to pc in PC_W+1 signed bits,
// and flags whether the result lands inside the program.
module pc_target_calc #(
   parameter int unsigned PC_W     = 10,
   parameter int unsigned OFFSET_W = 8,
   parameter int unsigned PROG_LEN = 1024
) (
   input  logic [PC_W-1:0]     pc,
   input  logic [OFFSET_W-1:0] branch_offset,
   output logic [PC_W-1:0]     target,
   output logic                in_range
);

   localparam int unsigned SUM_W = PC_W + 1;
   localparam logic signed [SUM_W-1:0] LAST_PC = SUM_W'(PROG_LEN - 1);

   logic signed [SUM_W-1:0] offsetExt;
   logic signed [SUM_W-1:0] pcExt;
   logic signed [SUM_W-1:0] sum;

   always_comb begin
      offsetExt = SUM_W'(signed'(branch_offset));
      pcExt     = signed'({1'b0, pc});
      sum       = pcExt + offsetExt;
      target    = sum[PC_W-1:0];
      // Negative targets show up as the sign bit; the upper bound is the last legal word.
      in_range  = !sum[SUM_W-1] && (sum <= LAST_PC);
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: sequences IDLE -> RUN -> DONE, picks pc+1 / taken BLQZ / halt,
// and keeps a saturating retired-instruction count plus a bad-branch fault flag.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int unsigned PC_W     = 10,
   parameter int unsigned OFFSET_W = 8,
   parameter int unsigned PROG_LEN = 1024,
   parameter int unsigned CNT_W    = 16
) (
   input  logic           clock,
   input  logic           reset_n,
   pc_sequencer_if.slave  bus
);

   localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);

   pc_seq_state_t    stateQ, stateD;
   logic [PC_W-1:0]  pcQ, pcD;
   logic [CNT_W-1:0] countQ, countD, countInc;
   logic             faultQ, faultD;
   logic [PC_W-1:0]  target;
   logic             inRange;
   logic             advance;
   logic             takeBranch;
   logic             launch;

   pc_target_calc #(
      .PC_W     (PC_W),
      .OFFSET_W (OFFSET_W),
      .PROG_LEN (PROG_LEN)
   ) u_target_calc (
      .pc            (pcQ),
      .branch_offset (bus.branch_offset),
      .target        (target),
      .in_range      (inRange)
   );

   assign advance    = (stateQ == RUN) && bus.next_ins;
   assign takeBranch = bus.branch_en && bus.branch_cond;
   assign launch     = (stateQ != RUN) && bus.start;
   assign countInc   = (&countQ) ? countQ : countQ + CNT_W'(1);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stateQ <= IDLE;
      end else begin
         stateQ <= stateD;
      end
   end

   always_comb begin
      stateD = stateQ;
      case (stateQ)
         IDLE: if (bus.start) stateD = RUN;
         RUN: begin
            if (bus.next_ins) begin
               if (bus.halt_ins) begin
                  stateD = DONE;
               end else if (takeBranch) begin
                  if (!inRange) stateD = DONE;
               end else if (pcQ == LAST_PC) begin
                  stateD = DONE;
               end
            end
         end
         DONE:    if (bus.start) stateD = RUN;
         default: stateD = IDLE;
      endcase
   end

   always_comb begin
      pcD    = pcQ;
      countD = countQ;
      faultD = faultQ;
      if (launch) begin
         pcD    = '0;
         countD = '0;
         faultD = 1'b0;
      end else if (advance) begin
         if (bus.halt_ins) begin
            countD = countInc;
         end else if (takeBranch) begin
            // A branch off the program does not retire; it only records the fault.
            if (inRange) begin
               pcD    = target;
               countD = countInc;
            end else begin
               faultD = 1'b1;
            end
         end else begin
            if (pcQ != LAST_PC) pcD = pcQ + PC_W'(1);
            countD = countInc;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pcQ    <= '0;
         countQ <= '0;
         faultQ <= 1'b0;
      end else begin
         pcQ    <= pcD;
         countQ <= countD;
         faultQ <= faultD;
      end
   end

   always_comb begin
      bus.pc        = pcQ;
      bus.ins_count = countQ;
      bus.fault     = faultQ;
      bus.running   = (stateQ == RUN);
      bus.done      = (stateQ == DONE);
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic against a behavioural model,
// with a second instance using a 2-bit counter to observe saturation.
module tb_pc_sequencer;

   localparam int unsigned PC_W     = 10;
   localparam int unsigned OFFSET_W = 8;
   localparam int unsigned PROG_LEN = 16;

   logic                clock = 1'b0;
   logic                reset_n = 1'b0;
   logic                start = 1'b0;
   logic                nextIns = 1'b0;
   logic                haltIns = 1'b0;
   logic                branchEn = 1'b0;
   logic                branchCond = 1'b0;
   logic [OFFSET_W-1:0] branchOffset = '0;

   int nChecks = 0;
   int nErrors = 0;

   typedef enum {M_IDLE, M_RUN, M_DONE} model_state_t;
   model_state_t mState;
   int           mPc;
   int           mCnt;
   bit           mFault;

   pc_sequencer_if #(.PC_W(PC_W), .OFFSET_W(OFFSET_W), .CNT_W(16)) busA ();
   pc_sequencer_if #(.PC_W(PC_W), .OFFSET_W(OFFSET_W), .CNT_W(2))  busB ();

   assign busA.start         = start;
   assign busA.next_ins      = nextIns;
   assign busA.halt_ins      = haltIns;
   assign busA.branch_en     = branchEn;
   assign busA.branch_cond   = branchCond;
   assign busA.branch_offset = branchOffset;
   assign busB.start         = start;
   assign busB.next_ins      = nextIns;
   assign busB.halt_ins      = haltIns;
   assign busB.branch_en     = branchEn;
   assign busB.branch_cond   = branchCond;
   assign busB.branch_offset = branchOffset;

   pc_sequencer #(
      .PC_W(PC_W), .OFFSET_W(OFFSET_W), .PROG_LEN(PROG_LEN), .CNT_W(16)
   ) dutA (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (busA)
   );

   pc_sequencer #(
      .PC_W(PC_W), .OFFSET_W(OFFSET_W), .PROG_LEN(PROG_LEN), .CNT_W(2)
   ) dutB (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (busB)
   );

   always #5 clock = ~clock;

   task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      mState = M_IDLE;
      mPc    = 0;
      mCnt   = 0;
      mFault = 1'b0;
   endtask

   // Behaviour of one clock edge, written straight from the sequencing rules.
   task automatic modelEdge(input bit st, input bit nx, input bit h, input bit be,
                            input bit bc, input int off);
      int t;
      if (mState != M_RUN) begin
         if (st) begin
            mState = M_RUN;
            mPc    = 0;
            mCnt   = 0;
            mFault = 1'b0;
         end
      end else if (nx) begin
         if (h) begin
            mState = M_DONE;
            mCnt++;
         end else if (be && bc) begin
            t = mPc + off;
            if (t >= 0 && t < int'(PROG_LEN)) begin
               mPc = t;
               mCnt++;
            end else begin
               mState = M_DONE;
               mFault = 1'b1;
            end
         end else if (mPc == int'(PROG_LEN) - 1) begin
            mState = M_DONE;
            mCnt++;
         end else begin
            mPc++;
            mCnt++;
         end
      end
   endtask

   task automatic checkAll(input string tag);
      checkEq({tag, " pc"}, 64'(busA.pc), 64'(mPc));
      checkEq({tag, " running"}, 64'(busA.running), 64'(mState == M_RUN));
      checkEq({tag, " done"}, 64'(busA.done), 64'(mState == M_DONE));
      checkEq({tag, " fault"}, 64'(busA.fault), 64'(mFault));
      checkEq({tag, " count"}, 64'(busA.ins_count), 64'((mCnt > 65535) ? 65535 : mCnt));
      checkEq({tag, " pc_b"}, 64'(busB.pc), 64'(mPc));
      checkEq({tag, " count_b"}, 64'(busB.ins_count), 64'((mCnt > 3) ? 3 : mCnt));
   endtask

   task automatic step(input bit st, input bit nx, input bit h, input bit be,
                       input bit bc, input int off);
      start        = st;
      nextIns      = nx;
      haltIns      = h;
      branchEn     = be;
      branchCond   = bc;
      branchOffset = OFFSET_W'(off);
      @(posedge clock);
      #1;
      modelEdge(st, nx, h, be, bc, off);
      start      = 1'b0;
      nextIns    = 1'b0;
      haltIns    = 1'b0;
      branchEn   = 1'b0;
      branchCond = 1'b0;
   endtask

   task automatic plain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
   endtask

   initial begin
      modelReset();
      #12;
      checkAll("reset");
      reset_n = 1'b1;

      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      plain(4);
      checkAll("four_plain");

      // Abort mid-run at pc=5 with no clock edge in between.
      plain(1);
      #2;
      reset_n = 1'b0;
      #1;
      modelReset();
      checkAll("async_reset");
      #1;
      reset_n = 1'b1;

      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      plain(10);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, -3);
      checkAll("blqz_taken");
      plain(3);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, -3);
      checkAll("blqz_not_taken");
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0);
      checkAll("self_loop");
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      checkAll("start_ignored_in_run");

      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      plain(2);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, -5);
      checkAll("blqz_fault");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      checkAll("restart");

      plain(15);
      checkAll("last_word");
      plain(1);
      checkAll("run_off_end");
      plain(1);
      checkAll("done_ignores_next");

      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      plain(3);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4);
      checkAll("halt_beats_branch");

      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      plain(6);
      checkAll("count_saturate");

      for (int i = 0; i < 400; i++) begin
         bit st, nx, h, be, bc;
         int off;
         st  = ($urandom_range(0, 99) < 8);
         nx  = ($urandom_range(0, 2) != 0);
         h   = ($urandom_range(0, 15) == 0);
         be  = ($urandom_range(0, 3) == 0);
         bc  = ($urandom_range(0, 1) == 1);
         off = int'($urandom_range(0, 24)) - 12;
         step(st, nx, h, be, bc, off);
         checkAll("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
